dac_sched: RTL

DAC_SCHED -- requirements
Module: dac_sched

---
 rtl/dac_sched_pkg.sv | 25 ++
 rtl/spi_frame_tx.sv | 64 ++++++
 rtl/dac_sched.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/dac_sched_pkg.sv
// Shared types and frame layout for the dual-channel DAC scheduler.
// Frame: {chan, BUF, GA, SHDN, data[9:0], 2'b00}, shifted MSB first.
package dac_sched_pkg;

    localparam int FRAME_W = 16;
    localparam int DATA_W  = 10;

    localparam logic FRAME_BUF  = 1'b0;
    localparam logic FRAME_GA   = 1'b1;
    localparam logic FRAME_SHDN = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_GAP,
        ST_LATCH
    } state_t;

    function automatic logic [FRAME_W-1:0] make_frame(input logic chan,
                                                      input logic [DATA_W-1:0] data);
        return {chan, FRAME_BUF, FRAME_GA, FRAME_SHDN, data, 2'b00};
    endfunction

endpackage

// File: rtl/spi_frame_tx.sv
// Serialises one 16-bit frame: 16 SCK periods of 2*SCK_HALF cycles, SCK idles low.
// start loads the frame; done pulses during the last cycle of the 16th high phase.
module spi_frame_tx
    import dac_sched_pkg::*;
#(
    parameter int SCK_HALF = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [FRAME_W-1:0] frame,
    output logic               done,
    output logic               sck,
    output logic               sdi
);

    localparam int PW = 8;
    localparam int BW = $clog2(FRAME_W);
    localparam logic [PW-1:0] PHASE_LAST = PW'(SCK_HALF - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(FRAME_W - 1);

    logic               active;
    logic [PW-1:0]      phase_cnt;
    logic [BW-1:0]      bit_cnt;
    logic [FRAME_W-1:0] sreg;
    logic               phase_end;

    assign phase_end = active && (phase_cnt == PHASE_LAST);
    assign done      = phase_end && sck && (bit_cnt == BIT_LAST);
    assign sdi       = active && sreg[FRAME_W-1];

    // Data only advances on the high->low SCK transition, so SDI is stable while SCK is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active    <= 1'b0;
            sck       <= 1'b0;
            phase_cnt <= '0;
            bit_cnt   <= '0;
            sreg      <= '0;
        end else if (start) begin
            active    <= 1'b1;
            sck       <= 1'b0;
            phase_cnt <= '0;
            bit_cnt   <= '0;
            sreg      <= frame;
        end else if (active) begin
            if (phase_end) begin
                phase_cnt <= '0;
                sck       <= ~sck;
                if (sck) begin
                    if (done) begin
                        active <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        sreg    <= {sreg[FRAME_W-2:0], 1'b0};
                    end
                end
            end else begin
                phase_cnt <= phase_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dac_sched.sv
// Per tick, sends channel A then channel B frames to a dual DAC, then one shared LDAC pulse.
// Frame = 1 + 32*SCK_HALF + CS_GAP cycles; ticks arriving while busy are dropped and flag overrun.
module dac_sched
    import dac_sched_pkg::*;
#(
    parameter int SCK_HALF = 2,
    parameter int CS_GAP   = 4,
    parameter int LD_WIDTH = 2
) (
    input  logic              CLOCK_50,
    input  logic              RESET_N,
    input  logic              tick,
    input  logic              req_a,
    input  logic [DATA_W-1:0] data_a,
    output logic              gnt_a,
    input  logic              req_b,
    input  logic [DATA_W-1:0] data_b,
    output logic              gnt_b,
    input  logic              clr_ovr,
    output logic              DAC_CS,
    output logic              SCK,
    output logic              DAC_SDI,
    output logic              DAC_LD,
    output logic              busy,
    output logic              overrun
);

    localparam int CW = 8;
    localparam logic [CW-1:0] GAP_LAST = CW'(CS_GAP - 1);
    localparam logic [CW-1:0] LD_LAST  = CW'(LD_WIDTH - 1);

    state_t             state, state_nxt;
    logic               pend_a, pend_a_nxt;
    logic               pend_b, pend_b_nxt;
    logic               sent, sent_nxt;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic               start;
    logic               done;
    logic [FRAME_W-1:0] frame;

    spi_frame_tx #(
        .SCK_HALF (SCK_HALF)
    ) u_tx (
        .clk   (CLOCK_50),
        .rst_n (RESET_N),
        .start (start),
        .frame (frame),
        .done  (done),
        .sck   (SCK),
        .sdi   (DAC_SDI)
    );

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state  <= ST_IDLE;
            pend_a <= 1'b0;
            pend_b <= 1'b0;
            sent   <= 1'b0;
            cnt    <= '0;
        end else begin
            state  <= state_nxt;
            pend_a <= pend_a_nxt;
            pend_b <= pend_b_nxt;
            sent   <= sent_nxt;
            cnt    <= cnt_nxt;
        end
    end

    // Set dominates clear so a tick lost in the same cycle as clr_ovr is never hidden.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            overrun <= 1'b0;
        end else if (tick && (state != ST_IDLE)) begin
            overrun <= 1'b1;
        end else if (clr_ovr) begin
            overrun <= 1'b0;
        end
    end

    assign busy = (state != ST_IDLE);

    always_comb begin
        state_nxt  = state;
        pend_a_nxt = pend_a;
        pend_b_nxt = pend_b;
        sent_nxt   = sent;
        cnt_nxt    = cnt;
        start      = 1'b0;
        frame      = '0;
        gnt_a      = 1'b0;
        gnt_b      = 1'b0;
        DAC_CS     = 1'b1;
        DAC_LD     = 1'b1;

        unique case (state)
            ST_IDLE: begin
                if (tick) begin
                    pend_a_nxt = req_a;
                    pend_b_nxt = req_b;
                    sent_nxt   = 1'b0;
                    if (req_a || req_b) begin
                        state_nxt = ST_LOAD;
                    end
                end
            end

            ST_LOAD: begin
                // A pending channel whose requester withdrew is skipped in the same cycle.
                if (pend_a && req_a) begin
                    frame      = make_frame(1'b0, data_a);
                    gnt_a      = 1'b1;
                    pend_a_nxt = 1'b0;
                end else if (pend_b && req_b) begin
                    frame      = make_frame(1'b1, data_b);
                    gnt_b      = 1'b1;
                    pend_a_nxt = 1'b0;
                    pend_b_nxt = 1'b0;
                end else begin
                    pend_a_nxt = 1'b0;
                    pend_b_nxt = 1'b0;
                end
                start = gnt_a || gnt_b;
                if (start) begin
                    DAC_CS    = 1'b0;
                    sent_nxt  = 1'b1;
                    state_nxt = ST_SHIFT;
                end else begin
                    cnt_nxt   = '0;
                    state_nxt = sent ? ST_LATCH : ST_IDLE;
                end
            end

            ST_SHIFT: begin
                DAC_CS = 1'b0;
                if (done) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_GAP;
                end
            end

            ST_GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = (pend_a || pend_b) ? ST_LOAD : ST_LATCH;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            ST_LATCH: begin
                DAC_LD = 1'b0;
                if (cnt == LD_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
